// File: rtl/monkey_collision_pkg.sv
// Shared constants and types for the monkey hit detector: counter slot indices,
// the frame FSM encoding and the default overlap counter width.
package monkey_collision_pkg;

    // Edge slots double as bit positions in HitEdgeCode.
    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;
    localparam int CAT_ROPE    = 4;
    localparam int CAT_BLOCK   = 5;
    localparam int CAT_ENEMY   = 6;
    localparam int NUM_CNT     = 7;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        WAIT_SOF,
        ACCUM
    } hitState_t;

endpackage

// File: rtl/monkey_hitdetect_counter.sv
// Saturating overlap-pixel counter; clr wins over inc and loads the current pixel.
module hit_counter
    import monkey_collision_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MIN_PIXELS = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic inc,
    input  logic clr,
    output logic meetsMin
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(CNT_W-1){1'b0}}, inc};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign meetsMin = (int'(count) >= MIN_PIXELS);

endmodule

// File: rtl/monkey_hitdetect.sv
// Per-frame monkey overlap detector: counts rope/block/enemy/edge-band overlap
// pixels and publishes frame-stable flags on startOfFrame. Option: HIT_DEBOUNCE_EN.
module monkey_hitdetect
    import monkey_collision_pkg::*;
#(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int EDGE_BAND  = 4,
    parameter int MIN_PIXELS = 3,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        drawingRequest_monkey,
    input  logic        drawingRequest_rope,
    input  logic        drawingRequest_block,
    input  logic        drawingRequest_enemy,
    output logic        onRope,
    output logic        onBlock,
    output logic        collision,
    output logic        objectHit,
    output logic        hitPulse,
    output logic [3:0]  HitEdgeCode
);

    hitState_t          state;
    logic               countEn;
    logic               publish;
    logic               blockPix;
    logic [NUM_CNT-1:0] overlapVec;
    logic [NUM_CNT-1:0] meetsVec;
    logic               ropeNext;
    logic               blockNext;
    logic [3:0]         edgeNext;

    // A pixel coinciding with startOfFrame belongs to the frame that starts.
    assign countEn  = (state == ACCUM) || startOfFrame;
    assign publish  = (state == ACCUM) && startOfFrame;
    assign blockPix = drawingRequest_monkey && drawingRequest_block;

    always_comb begin
        overlapVec              = '0;
        overlapVec[CAT_ROPE]    = drawingRequest_monkey && drawingRequest_rope;
        overlapVec[CAT_BLOCK]   = blockPix;
        overlapVec[CAT_ENEMY]   = drawingRequest_monkey && drawingRequest_enemy;
        overlapVec[EDGE_BOTTOM] = blockPix && (offsetY >= 11'(SPRITE_H - EDGE_BAND));
        overlapVec[EDGE_RIGHT]  = blockPix && (offsetX >= 11'(SPRITE_W - EDGE_BAND));
        overlapVec[EDGE_TOP]    = blockPix && (offsetY <  11'(EDGE_BAND));
        overlapVec[EDGE_LEFT]   = blockPix && (offsetX <  11'(EDGE_BAND));
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gCnt
            hit_counter #(
                .CNT_W      (CNT_W),
                .MIN_PIXELS (MIN_PIXELS)
            ) uCnt (
                .clk      (clk),
                .resetN   (resetN),
                .inc      (countEn && overlapVec[gi]),
                .clr      (startOfFrame),
                .meetsMin (meetsVec[gi])
            );
        end
    endgenerate

    assign edgeNext = meetsVec[EDGE_LEFT:EDGE_BOTTOM];

`ifdef HIT_DEBOUNCE_EN
    logic ropePrev;
    logic blockPrev;

    // Flags need two qualifying publishes in a row to rise, one failure drops them.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ropePrev  <= 1'b0;
            blockPrev <= 1'b0;
        end else if (publish) begin
            ropePrev  <= meetsVec[CAT_ROPE];
            blockPrev <= meetsVec[CAT_BLOCK];
        end
    end

    assign ropeNext  = meetsVec[CAT_ROPE] && ropePrev;
    assign blockNext = meetsVec[CAT_BLOCK] && blockPrev;
`else
    assign ropeNext  = meetsVec[CAT_ROPE];
    assign blockNext = meetsVec[CAT_BLOCK];
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= WAIT_SOF;
            onRope      <= 1'b0;
            onBlock     <= 1'b0;
            collision   <= 1'b0;
            objectHit   <= 1'b0;
            hitPulse    <= 1'b0;
            HitEdgeCode <= 4'b0000;
        end else begin
            hitPulse <= 1'b0;
            case (state)
                WAIT_SOF: begin
                    if (startOfFrame) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (publish) begin
                        onRope      <= ropeNext;
                        onBlock     <= blockNext;
                        collision   <= blockNext || (|edgeNext);
                        objectHit   <= meetsVec[CAT_ENEMY];
                        hitPulse    <= meetsVec[CAT_ENEMY] && !objectHit;
                        HitEdgeCode <= edgeNext;
                    end
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_monkey_hitdetect.sv
// Scoreboard bench for monkey_hitdetect: a frame-level model predicts each publish,
// a monitor checks the published value and that it is held until the next one.
module tb_monkey_hitdetect;

    localparam int SW   = 32;
    localparam int SH   = 32;
    localparam int EB   = 4;
    localparam int MINP = 3;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] offsetX = '0;
    logic [10:0] offsetY = '0;
    logic        drawingRequest_monkey = 1'b0;
    logic        drawingRequest_rope = 1'b0;
    logic        drawingRequest_block = 1'b0;
    logic        drawingRequest_enemy = 1'b0;
    logic        onRope, onBlock, collision, objectHit, hitPulse;
    logic [3:0]  HitEdgeCode;

    monkey_hitdetect #(
        .SPRITE_W(SW), .SPRITE_H(SH), .EDGE_BAND(EB), .MIN_PIXELS(MINP), .CNT_W(CW)
    ) dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .offsetX               (offsetX),
        .offsetY               (offsetY),
        .drawingRequest_monkey (drawingRequest_monkey),
        .drawingRequest_rope   (drawingRequest_rope),
        .drawingRequest_block  (drawingRequest_block),
        .drawingRequest_enemy  (drawingRequest_enemy),
        .onRope                (onRope),
        .onBlock               (onBlock),
        .collision             (collision),
        .objectHit             (objectHit),
        .hitPulse              (hitPulse),
        .HitEdgeCode           (HitEdgeCode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       onRope;
        logic       onBlock;
        logic       collision;
        logic       objectHit;
        logic       hitPulse;
        logic [3:0] edgeCode;
    } res_t;

    res_t expQ[$];
    res_t held;
    int   compared = 0;
    int   mismatched = 0;

    // Frame-level reference model state
    bit mAccum;
    int cRope, cBlock, cEnemy;
    int cEdge[4];
    bit prevRope, prevBlock;

    function automatic bit meets(input int c);
        int s;
        s = (c > CMAX) ? CMAX : c;
        return s >= MINP;
    endfunction

    task automatic modelReset();
        mAccum = 0;
        cRope = 0; cBlock = 0; cEnemy = 0;
        for (int k = 0; k < 4; k++) cEdge[k] = 0;
        prevRope = 0; prevBlock = 0;
        held = '0;
    endtask

    task automatic modelPublish();
        res_t r;
        bit rr, rb;
        rr = meets(cRope);
        rb = meets(cBlock);
`ifdef HIT_DEBOUNCE_EN
        r.onRope  = rr && prevRope;
        r.onBlock = rb && prevBlock;
`else
        r.onRope  = rr;
        r.onBlock = rb;
`endif
        prevRope = rr;
        prevBlock = rb;
        for (int k = 0; k < 4; k++) r.edgeCode[k] = meets(cEdge[k]);
        r.collision = r.onBlock || (r.edgeCode != 4'b0000);
        r.objectHit = meets(cEnemy);
        r.hitPulse  = r.objectHit && !held.objectHit;
        expQ.push_back(r);
        held = r;
        held.hitPulse = 1'b0;
    endtask

    task automatic step(input bit sof, input bit m, input bit r, input bit b,
                        input bit e, input int x, input int y);
        startOfFrame = sof;
        drawingRequest_monkey = m;
        drawingRequest_rope = r;
        drawingRequest_block = b;
        drawingRequest_enemy = e;
        offsetX = 11'(x);
        offsetY = 11'(y);
        if (sof) begin
            if (mAccum) modelPublish();
            else expQ.push_back(held);
            mAccum = 1;
            cRope = 0; cBlock = 0; cEnemy = 0;
            for (int k = 0; k < 4; k++) cEdge[k] = 0;
        end
        if (mAccum && m) begin
            if (r) cRope++;
            if (e) cEnemy++;
            if (b) begin
                cBlock++;
                if (y >= SH - EB) cEdge[0]++;
                if (x >= SW - EB) cEdge[1]++;
                if (y < EB)       cEdge[2]++;
                if (x < EB)       cEdge[3]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sofOnly();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset(input int cycles);
        startOfFrame = 0;
        drawingRequest_monkey = 0;
        drawingRequest_rope = 0;
        drawingRequest_block = 0;
        drawingRequest_enemy = 0;
        resetN = 0;
        modelReset();
        repeat (cycles) @(posedge clk);
        #1;
        resetN = 1;
    endtask

    // Monitor: outputs change only after a startOfFrame edge; otherwise they must hold.
    bit   sofSeen = 0;
    res_t cur = '0;

    always @(posedge clk) sofSeen = startOfFrame && resetN;

    task automatic check(input string name, input res_t act, input res_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t got{rope,block,coll,hit,pulse,edge}=%b required=%b",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t act;
        act = {onRope, onBlock, collision, objectHit, hitPulse, HitEdgeCode};
        if (!resetN) begin
            cur = '0;
            check("reset", act, '0);
        end else if (sofSeen) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL publish t=%0t got=%b required=<no prediction queued>", $time, act);
            end else begin
                cur = expQ.pop_front();
                check("publish", act, cur);
                cur.hitPulse = 1'b0;
            end
        end else begin
            check("hold", act, cur);
        end
    end

    initial begin
        modelReset();
        resetN = 0;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1;

        // Pixels before the first startOfFrame are ignored
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 5, 5);
        sofOnly();

        // Bottom-band block overlap, then an empty frame
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 10, 30);
        sofOnly();
        idle(20);
        sofOnly();

        // Threshold boundary: 2 then 3 rope pixels; non-monkey requests never count
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 12, 12);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 1, 0, 0);
        sofOnly();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 12, 12);
        sofOnly();

        // Saturation: 257 would wrap to 1 without saturation; two hit frames then none
        for (int i = 0; i < 257; i++) step(0, 1, 0, 0, 1, 16, 16);
        sofOnly();
        for (int i = 0; i < 257; i++) step(0, 1, 0, 0, 1, 16, 16);
        sofOnly();
        idle(5);
        sofOnly();

        // Pixel coincident with startOfFrame counts in the new frame; corner pixels
        step(1, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 31, 31);
        step(0, 1, 0, 1, 0, 2, 2);
        sofOnly();

        // Mid-frame reset: no publish until a second startOfFrame
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 30, 1);
        doReset(2);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 30, 1);
        sofOnly();
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 30, 1);
        sofOnly();

        // Rope frame pattern 1,1,0,1
        for (int f = 0; f < 4; f++) begin
            if (f != 2) for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 8, 8);
            idle(2);
            sofOnly();
        end

        // Randomized frames with a reset injected partway
        for (int f = 0; f < 40; f++) begin
            int len, pr, pb, pe;
            len = $urandom_range(10, 50);
            pr = $urandom_range(0, 3);
            pb = $urandom_range(0, 3);
            pe = $urandom_range(0, 3);
            if (f == 20) doReset(1);
            for (int i = 0; i < len; i++) begin
                step(i == 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) < pr,
                     $urandom_range(0, 9) < pb,
                     $urandom_range(0, 19) < pe,
                     $urandom_range(0, 40),
                     $urandom_range(0, 40));
            end
        end
        sofOnly();
        idle(3);

        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL drain got=%0d pending predictions required=0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
